// File: rtl/xnor_corr_detect.sv
// xnor_corr_detect: serial bit-stream correlator.
//   Shifts in_bit into an N-bit window (bit 0 newest), XNORs the window against
//   pattern, counts matching bits and flags hit when the count >= threshold.
//   Three-edge pipeline: shift -> xnor -> popcount/compare. Keeps a saturating
//   16-bit hit counter.
// Ports:
//   clk, rst_n (sync, active-low), in_valid/in_bit (serial input),
//   pattern [N-1:0], threshold [CW-1:0], clear (sync stream restart),
//   out_valid (1-cycle strobe), match_count [CW-1:0], hit, hit_count [15:0].
module xnor_corr_detect #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_bit,
  input  logic [N-1:0]  pattern,
  input  logic [CW-1:0] threshold,
  input  logic          clear,
  output logic          out_valid,
  output logic [CW-1:0] match_count,
  output logic          hit,
  output logic [15:0]   hit_count
);

  localparam int FW = $clog2(N + 1);

  logic [N-1:0]  window_q, window_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          s1_valid_q, s1_valid_d;
  logic [N-1:0]  xnor_q, xnor_d;
  logic [CW-1:0] thr_q, thr_d;
  logic          s2_valid_q, s2_valid_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] match_q, match_d;
  logic          hit_q, hit_d;
  logic [15:0]   hit_count_q, hit_count_d;
  logic [CW-1:0] pop;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pop = pop + CW'(xnor_q[i]);
    end
  end

  always_comb begin
    window_d    = window_q;
    fill_d      = fill_q;
    s1_valid_d  = 1'b0;
    xnor_d      = ~(window_q ^ pattern);
    thr_d       = threshold;
    s2_valid_d  = s1_valid_q;
    out_valid_d = s2_valid_q;
    match_d     = match_q;
    hit_d       = hit_q;
    hit_count_d = hit_count_q;

    if (in_valid) begin
      window_d = {window_q[N-2:0], in_bit};
      if (fill_q != FW'(N)) begin
        fill_d = fill_q + FW'(1);
      end
      s1_valid_d = (fill_d == FW'(N));
    end

    // threshold is captured alongside xnor so each result uses stage-2 values
    if (s2_valid_q) begin
      match_d = pop;
      hit_d   = (pop >= thr_q);
      if (hit_d && (hit_count_q != '1)) begin
        hit_count_d = hit_count_q + 16'd1;
      end
    end

    if (clear) begin
      window_d    = '0;
      fill_d      = '0;
      s1_valid_d  = 1'b0;
      s2_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      match_d     = '0;
      hit_d       = 1'b0;
      hit_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      window_q    <= '0;
      fill_q      <= '0;
      s1_valid_q  <= 1'b0;
      xnor_q      <= '0;
      thr_q       <= '0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      match_q     <= '0;
      hit_q       <= 1'b0;
      hit_count_q <= '0;
    end else begin
      window_q    <= window_d;
      fill_q      <= fill_d;
      s1_valid_q  <= s1_valid_d;
      xnor_q      <= xnor_d;
      thr_q       <= thr_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      match_q     <= match_d;
      hit_q       <= hit_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign match_count = match_q;
  assign hit         = hit_q;
  assign hit_count   = hit_count_q;

endmodule

// File: doc/xnor_corr_detect.md
# xnor_corr_detect

Serial bit-stream correlator that sits directly downstream of the bitwise XNOR compare stage. It shifts a 1-bit input stream into an N-bit window and XNORs the window against a programmable pattern. It then counts the matching bits and flags a hit when the count reaches a threshold. The block is pipelined, uses a valid handshake, and keeps a saturating hit counter for the stream.

## Interface
- N, default 8: window/pattern width in bits (2..32).
- CW, default $clog2(N+1): width of the match-count and threshold fields.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  input  1  in_bit is accepted on this edge.
- in_bit  input  1  serial data bit.
- pattern  input  N  reference pattern; bit 0 is compared with the newest bit.
- threshold  input  CW  minimum match count for a hit.
- clear  input  1  synchronous stream restart.
- out_valid  output  1  one-cycle strobe; match_count and hit are valid.
- match_count  output  CW  number of window bits equal to pattern (popcount of XNOR).
- hit  output  1  match_count >= threshold.
- hit_count  output  16  number of hits since reset/clear, saturating.

## Operation
- Window: on an accepted bit, window <= {window[N-2:0], in_bit}. window[0] is the newest bit. Feeding a pattern MSB-first leaves window == pattern.
- Fill counter: 0..N, increments per accepted bit and saturates at N. A sample produces a result only if the fill counter becomes N with that sample. The first N-1 samples after reset or clear produce no out_valid.
- Stage 1 (edge k, sample accepted): update window and fill counter. Set s1_valid = in_valid && window-full-after-shift.
- Stage 2 (edge k+1): register xnor_vec = ~(window ^ pattern), and sample pattern and threshold at this edge. Register s2_valid.
- Stage 3 (edge k+2): register match_count = popcount(xnor_vec) as an unsigned CW-bit value (maximum N, never overflows) and hit = (match_count >= threshold). out_valid = s2_valid.
- Threshold boundaries: threshold 0 gives hit=1 on every result. threshold > N gives hit=0 always.
- hit_count increments at edge k+2 when out_valid && hit, and holds at 16'hFFFF once reached.
- match_count and hit hold their last values while out_valid=0.
- clear: at the edge it is sampled, zero the window, fill counter, s1_valid/s2_valid, out_valid, match_count, hit and hit_count.
  - Results in flight are discarded.
  - clear wins over in_valid in the same cycle; that bit is dropped.
- rst_n low: same effect as clear, and rst_n has priority over clear. Reset mid-stream discards all in-flight samples.

## Timing
- Reset values: out_valid=0, match_count=0, hit=0, hit_count=0, window=0, fill=0.
- Latency: a bit accepted at edge k has its result on the outputs after edge k+2, with out_valid high for exactly one cycle.
- Throughput: one bit per clock. There is no backpressure; in_valid may be high continuously or have any number of idle gaps.
- Back-to-back valid bits produce back-to-back out_valid strobes once the window is full.
- pattern and threshold may change at any time. Each result uses the values present at its stage-2 edge.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid toggling -> out_valid, match_count, hit and hit_count all 0 throughout and one cycle after release.
- Fill and match: N=8, pattern=8'hA5, threshold=8; feed 1,0,1,0,0,1,0,1 on consecutive cycles -> no out_valid for the first 7 bits; 2 cycles after the 8th bit, out_valid=1, match_count=8, hit=1, hit_count=1.
- Partial match: continue with bit 1 (window=8'h4B) -> next out_valid gives match_count=2, hit=0, hit_count stays 1. Then set threshold=2 and feed one more bit -> check hit against the resulting popcount.
- Gapped input: repeat the fill with 0-3 idle cycles between bits -> out_valid only for accepted bits, each exactly 2 edges after acceptance; results identical to the gap-free run.
- Clear mid-stream: assert clear together with in_valid=1 while a result is in flight -> no out_valid from in-flight samples, hit_count=0, the dropped bit is not shifted in, and 8 new bits are needed before the next out_valid.
- Saturation: threshold=0 with a continuous valid stream of 65,545 bits -> every result has hit=1, and hit_count reaches 16'hFFFF and holds.
